// File: rtl/shift_control.sv
// rtl/shift_control.sv - registered opcode/function-field decode to shifter operation select
// sh_op: 00 pass, 01 SLL, 10 SRL, 11 SRA; one clock of latency to line up with the execute stage.
module shift_control #(
  parameter int OPW = 4,
  parameter int FW  = 4,
  parameter logic [OPW-1:0] OP_RTYPE = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  ffield,
  output logic [1:0]     sh_op
);

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRL  = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  localparam logic [FW-1:0] F_SLL = FW'(1);
  localparam logic [FW-1:0] F_SRL = FW'(2);
  localparam logic [FW-1:0] F_SRA = FW'(3);

  logic [1:0] sh_next;

  // Only R-type consults the function field; everything else keeps the shifter transparent.
  always_comb begin
    sh_next = SH_PASS;
    if (opcode == OP_RTYPE) begin
      case (ffield)
        F_SLL:   sh_next = SH_SLL;
        F_SRL:   sh_next = SH_SRL;
        F_SRA:   sh_next = SH_SRA;
        default: sh_next = SH_PASS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_op <= SH_PASS;
    end else begin
      sh_op <= sh_next;
    end
  end

endmodule

// File: tb/tb_shift_control.sv
// tb/tb_shift_control.sv - self-checking bench for shift_control
module tb_shift_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [3:0] ffield;
  logic [1:0] sh_op;

  int errors = 0;
  int checks = 0;

  shift_control dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .ffield (ffield),
    .sh_op  (sh_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] opcode;
    logic [3:0] ffield;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference rule: only opcode 0 with ffield 1..3 shifts, and the code equals ffield.
  function automatic logic [1:0] model(input logic r, input logic [3:0] op, input logic [3:0] ff);
    int f;
    f = int'(ff);
    if (r) return 2'd0;
    if (op != 4'd0) return 2'd0;
    if (f >= 1 && f <= 3) return 2'(f);
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] op, input logic [3:0] ff);
    @(negedge clk);
    rst    = r;
    opcode = op;
    ffield = ff;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp;
    logic       r;
    logic [3:0] op;
    logic [3:0] ff;

    rst = 1'b1;
    opcode = 4'd0;
    ffield = 4'd0;

    vecs.push_back('{1'b1, 4'h0, 4'h1, 2'b00});
    vecs.push_back('{1'b1, 4'h0, 4'h1, 2'b00});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 2'b00});
    vecs.push_back('{1'b0, 4'h0, 4'h1, 2'b01});
    vecs.push_back('{1'b0, 4'h0, 4'h2, 2'b10});
    vecs.push_back('{1'b0, 4'h0, 4'h3, 2'b11});
    vecs.push_back('{1'b0, 4'h0, 4'h5, 2'b00});
    vecs.push_back('{1'b0, 4'h0, 4'hF, 2'b00});
    vecs.push_back('{1'b0, 4'h0, 4'h4, 2'b00});
    vecs.push_back('{1'b0, 4'h1, 4'h1, 2'b00});
    vecs.push_back('{1'b0, 4'h2, 4'h1, 2'b00});
    vecs.push_back('{1'b0, 4'h4, 4'h1, 2'b00});
    vecs.push_back('{1'b0, 4'h8, 4'h1, 2'b00});
    vecs.push_back('{1'b0, 4'hF, 4'h3, 2'b00});
    vecs.push_back('{1'b0, 4'h0, 4'h3, 2'b11});
    vecs.push_back('{1'b1, 4'h0, 4'h3, 2'b00});
    vecs.push_back('{1'b0, 4'h0, 4'h3, 2'b11});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].opcode, vecs[i].ffield);
      check($sformatf("vec%0d", i), sh_op, vecs[i].exp);
    end

    // Output must hold between edges even though the inputs changed.
    step(1'b0, 4'h0, 4'h2);
    check("pre_hold", sh_op, 2'b10);
    @(negedge clk);
    opcode = 4'h0;
    ffield = 4'h1;
    #2;
    check("hold_mid_cycle", sh_op, 2'b10);
    @(posedge clk);
    #1;
    check("after_hold_edge", sh_op, 2'b01);

    // Reset asserted mid-stream, then first decode appears one edge after release.
    step(1'b1, 4'h0, 4'h2);
    check("mid_reset", sh_op, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("release_no_edge", sh_op, 2'b00);
    @(posedge clk);
    #1;
    check("first_after_release", sh_op, 2'b10);

    for (int i = 0; i < 1000; i++) begin
      r  = ($urandom_range(0, 31) == 0);
      op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      ff = 4'($urandom_range(0, 15));
      exp = model(r, op, ff);
      step(r, op, ff);
      check($sformatf("rand%0d op=%h ff=%h rst=%b", i, op, ff, r), sh_op, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
